// File: rtl/ahb_cache_miss_arbiter.sv
// Two-port read-only AHB arbiter merging cache-miss requests onto one downstream bus.
// Each port buffers its address phase, waits for a grant, then relays the data phase.
module ahb_cache_miss_arbiter #(
  parameter int W_ADDR      = 32,
  parameter int W_DATA      = 32,
  parameter int ROUND_ROBIN = 1
) (
  input  logic              clk,
  input  logic              rst_n,

  input  logic              src0_hready,
  output logic              src0_hready_resp,
  output logic              src0_hresp,
  input  logic [W_ADDR-1:0] src0_haddr,
  input  logic [1:0]        src0_htrans,
  input  logic [2:0]        src0_hsize,
  input  logic [3:0]        src0_hprot,
  output logic [W_DATA-1:0] src0_hrdata,

  input  logic              src1_hready,
  output logic              src1_hready_resp,
  output logic              src1_hresp,
  input  logic [W_ADDR-1:0] src1_haddr,
  input  logic [1:0]        src1_htrans,
  input  logic [2:0]        src1_hsize,
  input  logic [3:0]        src1_hprot,
  output logic [W_DATA-1:0] src1_hrdata,

  input  logic              dst_hready_resp,
  output logic              dst_hready,
  input  logic              dst_hresp,
  output logic [W_ADDR-1:0] dst_haddr,
  output logic [1:0]        dst_htrans,
  output logic [2:0]        dst_hsize,
  output logic [3:0]        dst_hprot,
  input  logic [W_DATA-1:0] dst_hrdata,
  output logic              dst_hwrite,
  output logic [2:0]        dst_hburst,
  output logic              dst_hmastlock,
  output logic [W_DATA-1:0] dst_hwdata
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DATA = 2'd2
  } port_state_t;

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  port_state_t       state      [2];
  port_state_t       state_next [2];
  logic [W_ADDR-1:0] buf_addr   [2];
  logic [2:0]        buf_size   [2];
  logic [3:0]        buf_prot   [2];

  logic [W_ADDR-1:0] src_haddr [2];
  logic [2:0]        src_hsize [2];
  logic [3:0]        src_hprot [2];
  logic [1:0]        src_hready;
  logic [1:0]        src_req;
  logic [1:0]        ready_resp;
  logic [1:0]        capture;
  logic [1:0]        in_wait;
  logic [1:0]        in_data;

  logic grant;
  logic hold_valid;
  logic hold_grant;
  logic last_grant;
  logic err_drop;
  logic accept;
  logic unused_htrans_bits;

  assign src_haddr[0] = src0_haddr;
  assign src_haddr[1] = src1_haddr;
  assign src_hsize[0] = src0_hsize;
  assign src_hsize[1] = src1_hsize;
  assign src_hprot[0] = src0_hprot;
  assign src_hprot[1] = src1_hprot;
  assign src_hready   = {src1_hready, src0_hready};
  assign src_req      = {src1_htrans[1], src0_htrans[1]};

  // Only NONSEQ vs IDLE matters to a miss port; the SEQ/BUSY bit is ignored.
  assign unused_htrans_bits = &{1'b0, src0_htrans[0], src1_htrans[0]};

  always_comb begin
    for (int i = 0; i < 2; i++) begin
      in_wait[i]    = (state[i] == S_WAIT);
      in_data[i]    = (state[i] == S_DATA);
      ready_resp[i] = (state[i] == S_IDLE) ? 1'b1 :
                      (state[i] == S_DATA) ? dst_hready_resp : 1'b0;
      capture[i]    = src_hready[i] && src_req[i] && ready_resp[i];
    end
  end

  // An erroring data phase forces IDLE on the address bus for both error cycles.
  assign err_drop = (|in_data) && dst_hresp;

  always_comb begin
    grant = 1'b0;
    if (hold_valid) begin
      grant = hold_grant;
    end else if (in_wait[0] && in_wait[1]) begin
      grant = (ROUND_ROBIN != 0) ? ~last_grant : 1'b0;
    end else if (in_wait[1]) begin
      grant = 1'b1;
    end
  end

  assign dst_htrans = ((|in_wait) && !err_drop) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign dst_hready = dst_hready_resp;
  assign accept     = dst_htrans[1] && dst_hready_resp;

  assign dst_haddr = buf_addr[grant];
  assign dst_hsize = buf_size[grant];
  assign dst_hprot = buf_prot[grant];

  assign dst_hwrite    = 1'b0;
  assign dst_hburst    = 3'b000;
  assign dst_hmastlock = 1'b0;
  assign dst_hwdata    = '0;

  assign src0_hready_resp = ready_resp[0];
  assign src1_hready_resp = ready_resp[1];
  assign src0_hresp       = in_data[0] ? dst_hresp : 1'b0;
  assign src1_hresp       = in_data[1] ? dst_hresp : 1'b0;
  assign src0_hrdata      = dst_hrdata;
  assign src1_hrdata      = dst_hrdata;

  // A completing data phase may immediately re-queue when the port captures again.
  always_comb begin
    for (int i = 0; i < 2; i++) begin
      state_next[i] = state[i];
      case (state[i])
        S_IDLE: if (capture[i]) state_next[i] = S_WAIT;
        S_WAIT: if (accept && (grant == 1'(i))) state_next[i] = S_DATA;
        S_DATA: if (dst_hready_resp) state_next[i] = capture[i] ? S_WAIT : S_IDLE;
        default: state_next[i] = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        state[i]    <= S_IDLE;
        buf_addr[i] <= '0;
        buf_size[i] <= '0;
        buf_prot[i] <= '0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        state[i] <= state_next[i];
        if (capture[i]) begin
          buf_addr[i] <= src_haddr[i];
          buf_size[i] <= src_hsize[i];
          buf_prot[i] <= src_hprot[i];
        end
      end
    end
  end

  // A stalled NONSEQ pins the grant so the downstream address stays stable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_valid <= 1'b0;
      hold_grant <= 1'b0;
      last_grant <= 1'b1;
    end else begin
      hold_valid <= dst_htrans[1] && !dst_hready_resp;
      hold_grant <= grant;
      if (accept) last_grant <= grant;
    end
  end

endmodule

// File: doc/ahb_cache_miss_arbiter.md
AHB_CACHE_MISS_ARBITER -- requirements
Module: ahb_cache_miss_arbiter

Interface
REQ-001 Parameter W_ADDR, default 32: address width.
REQ-002 Parameter W_DATA, default 32: data width.
REQ-003 Parameter ROUND_ROBIN, default 1: 1 = alternating priority; 0 = port 0 always wins.
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 rst_n  input  1  reset, asynchronous, active-low.
REQ-006 srcN_hready (N=0,1)  input  1  upstream bus HREADY for port N.
REQ-007 srcN_hready_resp  output  1  port N HREADYOUT.
REQ-008 srcN_hresp  output  1  port N HRESP.
REQ-009 srcN_haddr  input  W_ADDR  port N address.
REQ-010 srcN_htrans  input  2  port N HTRANS.
REQ-011 srcN_hsize  input  3  port N HSIZE.
REQ-012 srcN_hprot  input  4  port N HPROT.
REQ-013 srcN_hrdata  output  W_DATA  port N read data.
REQ-014 dst_hready_resp  input  1  downstream HREADYOUT.
REQ-015 dst_hready  output  1  downstream HREADY; equals dst_hready_resp.
REQ-016 dst_hresp  input  1  downstream HRESP.
REQ-017 dst_haddr / dst_hsize / dst_hprot  output  W_ADDR/3/4  request fields from the granted buffer.
REQ-018 dst_htrans  output  2  IDLE (00) or NONSEQ (10) only.
REQ-019 dst_hrdata  input  W_DATA  downstream read data.
REQ-020 dst_hwrite, dst_hburst, dst_hmastlock, dst_hwdata  output  tied to 0 (read-only arbiter; both ports are read-only cache miss ports).

Function
REQ-021 Each port SHALL have state IDLE, WAIT or DATA plus a buffer holding addr/size/prot.
REQ-022 Capture condition: srcN_hready && srcN_htrans[1] && srcN_hready_resp; on capture, the buffer loads and the port enters WAIT.
REQ-023 srcN_hready_resp SHALL be 1 in IDLE, 0 in WAIT, and equal dst_hready_resp in DATA.
REQ-024 srcN_hresp SHALL equal dst_hresp in DATA, else 0.
REQ-025 srcN_hrdata SHALL equal dst_hrdata combinationally for both ports.
REQ-026 dst_htrans SHALL be NONSEQ when any port is in WAIT, except in a cycle where a downstream data phase is active and dst_hresp=1; then it SHALL be IDLE.
REQ-027 Grant, when both ports are in WAIT: ROUND_ROBIN=1 selects the port not granted last; ROUND_ROBIN=0 selects port 0.
REQ-028 With only one port in WAIT, that port SHALL be granted.
REQ-029 Grant hold: once NONSEQ is driven with dst_hready=0, the grant and dst_haddr/hsize/hprot SHALL stay unchanged until dst_hready=1 or the error drop in REQ-026.
REQ-030 Address phase accepted (dst_htrans[1] && dst_hready): the granted port moves WAIT->DATA, owner<=granted, last_grant<=granted.
REQ-031 DATA->IDLE when dst_hready=1.
REQ-032 DATA->WAIT instead of IDLE when a new capture occurs in the same cycle.
REQ-033 A capture on one port SHALL proceed regardless of grant or data-phase activity on the other port.
REQ-034 With no port in WAIT, dst_haddr/hsize/hprot SHALL show the port 0 buffer.
REQ-035 Error response: dst cycle 1 (hresp=1, hready=0) gives the owner hresp=1, hready_resp=0; cycle 2 (hresp=1, hready=1) gives hresp=1, hready_resp=1. The owner then returns to IDLE, or WAIT on capture.
REQ-036 Latency: src address phase at cycle T -> dst address phase T+1 -> src completes at T+2 with a zero-wait slave (minimum 1 upstream wait state).
REQ-037 Each further downstream wait state or lost arbitration SHALL add one cycle.

Reset
REQ-038 Asynchronous reset SHALL, including mid-transfer, force:
- both ports IDLE, buffers 0, grant hold cleared;
- last_grant=1 (port 0 wins first contention);
- outputs: srcN_hready_resp=1, srcN_hresp=0, dst_htrans=00, dst_haddr=0, dst_hsize=0, dst_hprot=0.

Verification
REQ-039 Port 0 reads 0x100 and dst has zero wait states -> dst NONSEQ 0x100 at T+1, src0_hready_resp=1 at T+2 with dst_hrdata.
REQ-040 Both ports request at T, 0x100 and 0x200, with RR=1 after reset -> 0x100 issued T+1, 0x200 issued T+2, src0 done T+2, src1 done T+3.
REQ-041 dst holds hready=0 for 3 cycles while port 1 is waiting and port 0 then requests (RR=0) -> dst_haddr stays at port 1 address until accepted.
REQ-042 Port 1 gets an ERROR with port 0 in WAIT -> src1 sees the two-cycle error, dst_htrans=IDLE in error cycle 1, port 0 issued afterward.
REQ-043 Back-to-back port 0 reads on a completing cycle -> port 0 goes DATA->WAIT with no IDLE gap.
REQ-044 rst_n asserted mid data phase -> all outputs take their reset values immediately, without waiting for clk.
